// File: rtl/axis_uart_rx_fifo.sv
// 8N1 UART receiver feeding a first-word-fall-through byte FIFO with an AXI-Stream master output.
// Overrun and frame errors are reported as one-cycle pulses following the stop-sample edge.
module axis_uart_rx_fifo #(
    parameter int RX_SIZE   = 4,
    parameter int clkdiv_rx = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] o_tdata,
    output logic       o_tvalid,
    input  logic       o_tready,
    output logic       o_overrun,
    output logic       o_frame_err
);

    localparam int CNT_W = $clog2(clkdiv_rx + 1);
    localparam int DEPTH = 1 << RX_SIZE;

    localparam logic [CNT_W-1:0]   HALF_BIT = CNT_W'(clkdiv_rx / 2);
    localparam logic [CNT_W-1:0]   FULL_BIT = CNT_W'(clkdiv_rx);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [RX_SIZE:0]   DEPTH_C  = (RX_SIZE + 1)'(DEPTH);
    localparam logic [RX_SIZE-1:0] PTR_ONE  = RX_SIZE'(1);
    localparam logic [RX_SIZE:0]   CNT1_F   = (RX_SIZE + 1)'(1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;

    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic [2:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;
    logic             expire;
    logic             push_req;

    logic [7:0]         mem [DEPTH];
    logic [RX_SIZE-1:0] wr_ptr;
    logic [RX_SIZE-1:0] rd_ptr;
    logic [RX_SIZE:0]   count;
    logic               pop;
    logic               push_ok;

    // rx_prev resets low so a line held low through reset cannot look like a start edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b0;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    assign expire   = (cnt == CNT_ONE);
    assign push_req = (state == STOP) && expire && rx_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= HALF_BIT;
                        state <= START;
                    end
                end
                START: begin
                    if (expire) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            cnt     <= FULL_BIT;
                            bit_idx <= '0;
                            state   <= DATA;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                DATA: begin
                    if (expire) begin
                        cnt     <= FULL_BIT;
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                STOP: begin
                    // Returning to IDLE here leaves half a bit to catch a back-to-back start edge
                    if (expire) begin
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            o_frame_err <= 1'b1;
                            state       <= WAIT_IDLE;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                WAIT_IDLE: begin
                    if (rx_s) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state == DATA && expire) shreg <= {rx_s, shreg[7:1]};
    end

    // A push into a full FIFO still fits when a pop frees the head slot on the same edge
    assign pop     = o_tvalid && o_tready;
    assign push_ok = push_req && ((count < DEPTH_C) || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            o_overrun <= 1'b0;
        end else begin
            o_overrun <= push_req && !push_ok;
            if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
            case ({push_ok, pop})
                2'b10:   count <= count + CNT1_F;
                2'b01:   count <= count - CNT1_F;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= shreg;
    end

    assign o_tvalid = (count != '0);
    assign o_tdata  = o_tvalid ? mem[rd_ptr] : 8'h00;

endmodule

// File: tb/tb_axis_uart_rx_fifo.sv
// Self-checking bench for axis_uart_rx_fifo: serial frames are driven on rx, expected bytes
// go into a scoreboard queue and are compared whenever the DUT hands over a byte.
module tb_axis_uart_rx_fifo;

    localparam int DIV = 50;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tready;
    logic       o_overrun;
    logic       o_frame_err;

    int checks   = 0;
    int failures = 0;
    int pop_cnt  = 0;
    int ovr_cnt  = 0;
    int ferr_cnt = 0;
    logic [7:0] exp_q[$];

    axis_uart_rx_fifo #(.RX_SIZE(4), .clkdiv_rx(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (rx),
        .o_tdata    (o_tdata),
        .o_tvalid   (o_tvalid),
        .o_tready   (o_tready),
        .o_overrun  (o_overrun),
        .o_frame_err(o_frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change on the falling edge; the monitor looks 1 ns later at what the next rising edge will use
    always @(negedge clk) begin
        logic [7:0] exp_b;
        #1;
        if (!rst) begin
            if (o_overrun)   ovr_cnt++;
            if (o_frame_err) ferr_cnt++;
            if (o_tvalid && o_tready) begin
                pop_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL pop_unexpected got=%02h expected=none", o_tdata);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (o_tdata !== exp_b) begin
                        failures++;
                        $display("FAIL pop_data got=%02h expected=%02h", o_tdata, exp_b);
                    end
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        rx = 1'b0;
        wait_cycles(DIV);
        for (int i = 0; i < 8; i++) begin
            rx = data[i];
            wait_cycles(DIV);
        end
        rx = stop_bit;
        wait_cycles(DIV);
        if (stop_bit) rx = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1; rx = 1'b1; o_tready = 1'b0;
        wait_cycles(4);
        checks++; if (o_tvalid !== 1'b0)    begin failures++; $display("FAIL reset_tvalid got=%b expected=0", o_tvalid); end
        checks++; if (o_tdata !== 8'h00)    begin failures++; $display("FAIL reset_tdata got=%02h expected=00", o_tdata); end
        checks++; if (o_overrun !== 1'b0)   begin failures++; $display("FAIL reset_overrun got=%b expected=0", o_overrun); end
        checks++; if (o_frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b expected=0", o_frame_err); end
        rst = 1'b0;
        wait_cycles(10);
    endtask

    task automatic test_single_byte;
        int first_k = -1;
        int high_n  = 0;
        int p0 = pop_cnt, o0 = ovr_cnt, f0 = ferr_cnt;
        o_tready = 1'b1;
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                for (int k = 0; k < 490; k++) begin
                    @(posedge clk);
                    @(negedge clk);
                    if (o_tvalid === 1'b1) begin
                        high_n++;
                        if (first_k < 0) first_k = k;
                    end
                end
            end
        join
        wait_cycles(20);
        checks++; if (first_k != 477) begin failures++; $display("FAIL single_first_edge got=%0d expected=477", first_k); end
        checks++; if (high_n != 1)    begin failures++; $display("FAIL single_valid_cycles got=%0d expected=1", high_n); end
        checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL single_pops got=%0d expected=1", pop_cnt - p0); end
        checks++; if (ovr_cnt != o0 || ferr_cnt != f0) begin
            failures++; $display("FAIL single_err_pulses got=%0d/%0d expected=0/0", ovr_cnt - o0, ferr_cnt - f0);
        end
    endtask

    task automatic test_burst_overrun;
        logic [7:0] bytes [17] = '{8'h55, 8'h55, 8'h55, 8'h00, 8'hAA, 8'hFF, 8'h53, 8'hCA, 8'h5A,
                                   8'hA5, 8'h55, 8'h55, 8'h00, 8'hAA, 8'hFF, 8'h53, 8'h18};
        int o0 = ovr_cnt;
        int p0;
        o_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(bytes[i]);
            send_byte(bytes[i], 1'b1);
        end
        checks++; if (ovr_cnt != o0) begin failures++; $display("FAIL burst_early_overrun got=%0d expected=0", ovr_cnt - o0); end
        send_byte(bytes[16], 1'b1);
        wait_cycles(10);
        checks++; if (ovr_cnt - o0 != 1) begin failures++; $display("FAIL burst_overrun got=%0d expected=1", ovr_cnt - o0); end
        p0 = pop_cnt;
        o_tready = 1'b1;
        wait_cycles(16);
        #2;
        checks++; if (pop_cnt - p0 != 16) begin failures++; $display("FAIL burst_drain_rate got=%0d expected=16", pop_cnt - p0); end
        checks++; if (o_tvalid !== 1'b0)  begin failures++; $display("FAIL burst_drain_empty got=%b expected=0", o_tvalid); end
        wait_cycles(5);
        checks++; if (exp_q.size() != 0 || pop_cnt - p0 != 16) begin
            failures++; $display("FAIL burst_left got=%0d/%0d expected=0/16", exp_q.size(), pop_cnt - p0);
        end
    endtask

    task automatic test_glitch;
        int p0 = pop_cnt, o0 = ovr_cnt, f0 = ferr_cnt;
        o_tready = 1'b1;
        rx = 1'b0;
        wait_cycles(10);
        rx = 1'b1;
        wait_cycles(100);
        checks++; if (pop_cnt != p0) begin failures++; $display("FAIL glitch_valid got=%0d expected=0", pop_cnt - p0); end
        checks++; if (ovr_cnt != o0 || ferr_cnt != f0) begin
            failures++; $display("FAIL glitch_pulses got=%0d/%0d expected=0/0", ovr_cnt - o0, ferr_cnt - f0);
        end
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        wait_cycles(20);
        checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL glitch_next_frame got=%0d expected=1", pop_cnt - p0); end
    endtask

    task automatic test_frame_error;
        int p0 = pop_cnt, f0 = ferr_cnt, o0 = ovr_cnt;
        o_tready = 1'b1;
        send_byte(8'h3C, 1'b0);
        wait_cycles(2000);
        checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL ferr_pulses got=%0d expected=1", ferr_cnt - f0); end
        checks++; if (pop_cnt != p0 || ovr_cnt != o0) begin
            failures++; $display("FAIL ferr_push got=%0d/%0d expected=0/0", pop_cnt - p0, ovr_cnt - o0);
        end
        rx = 1'b1;
        wait_cycles(20);
        exp_q.push_back(8'h81);
        send_byte(8'h81, 1'b1);
        wait_cycles(20);
        checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL ferr_recover got=%0d expected=1", pop_cnt - p0); end
        checks++; if (ferr_cnt - f0 != 1) begin failures++; $display("FAIL ferr_after got=%0d expected=1", ferr_cnt - f0); end
    endtask

    task automatic test_full_simul_pop;
        int o0 = ovr_cnt;
        int p0;
        logic [7:0] b;
        o_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            b = 8'(i * 37 + 11);
            exp_q.push_back(b);
            send_byte(b, 1'b1);
        end
        exp_q.push_back(8'h7E);
        p0 = pop_cnt;
        fork
            send_byte(8'h7E, 1'b1);
            begin
                wait_cycles(477);
                o_tready = 1'b1;
                wait_cycles(1);
                o_tready = 1'b0;
            end
        join
        wait_cycles(5);
        checks++; if (ovr_cnt != o0) begin failures++; $display("FAIL full_overrun got=%0d expected=0", ovr_cnt - o0); end
        checks++; if (pop_cnt - p0 != 1) begin failures++; $display("FAIL full_coincident_pop got=%0d expected=1", pop_cnt - p0); end
        p0 = pop_cnt;
        o_tready = 1'b1;
        wait_cycles(16);
        #2;
        checks++; if (pop_cnt - p0 != 16 || o_tvalid !== 1'b0) begin
            failures++; $display("FAIL full_count got=%0d valid=%b expected=16 valid=0", pop_cnt - p0, o_tvalid);
        end
        wait_cycles(5);
    endtask

    task automatic test_reset_mid_frame;
        int p0;
        o_tready = 1'b0;
        exp_q.push_back(8'h11); send_byte(8'h11, 1'b1);
        exp_q.push_back(8'h22); send_byte(8'h22, 1'b1);
        exp_q.push_back(8'h33); send_byte(8'h33, 1'b1);
        checks++; if (o_tvalid !== 1'b1) begin failures++; $display("FAIL rstmid_queued got=%b expected=1", o_tvalid); end
        fork
            send_byte(8'h99, 1'b1);
            begin
                wait_cycles(DIV + 4 * DIV + DIV / 2);
                rst = 1'b1;
                exp_q.delete();
                wait_cycles(3);
                checks++; if (o_tvalid !== 1'b0)    begin failures++; $display("FAIL rstmid_tvalid got=%b expected=0", o_tvalid); end
                checks++; if (o_tdata !== 8'h00)    begin failures++; $display("FAIL rstmid_tdata got=%02h expected=00", o_tdata); end
                checks++; if (o_overrun !== 1'b0 || o_frame_err !== 1'b0) begin
                    failures++; $display("FAIL rstmid_pulses got=%b%b expected=00", o_overrun, o_frame_err);
                end
            end
        join
        wait_cycles(5);
        rst = 1'b0;
        wait_cycles(10);
        checks++; if (o_tvalid !== 1'b0) begin failures++; $display("FAIL rstmid_empty got=%b expected=0", o_tvalid); end
        p0 = pop_cnt;
        o_tready = 1'b1;
        exp_q.push_back(8'h18);
        send_byte(8'h18, 1'b1);
        wait_cycles(20);
        checks++; if (pop_cnt - p0 != 1 || exp_q.size() != 0) begin
            failures++; $display("FAIL rstmid_after got=%0d left=%0d expected=1 left=0", pop_cnt - p0, exp_q.size());
        end
    endtask

    initial begin
        rst = 1'b1;
        rx = 1'b1;
        o_tready = 1'b0;
        test_reset();
        test_single_byte();
        test_burst_overrun();
        test_glitch();
        test_frame_error();
        test_full_simul_pop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_uart_rx_fifo.md
# axis_uart_rx_fifo

UART receiver with an AXI-Stream master output and a receive FIFO. It is the downstream counterpart of the AXIS UART transmitter: it takes the serial line driven by the FTDI bridge (or looped back from the transmitter), deframes 8N1 bytes, and buffers them for the modem datapath. One instance sits between the UART_RX pin and the byte consumer in the MDM FTDI top level.

## Interface
- RX_SIZE, 4: FIFO address width; the FIFO depth is 2^RX_SIZE entries (16 by default).
- clkdiv_rx, 50: clock cycles per UART bit. Must be ≥ 4. The default gives 80 kbaud at the 4 MHz CLOCK.

- clk  in  1  system clock. This is the one clock of the block.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input. It idles high and is asynchronous to clk.
- o_tdata  out  8  received byte at the FIFO head.
- o_tvalid  out  1  FIFO not empty.
- o_tready  in  1  consumer accepts o_tdata.
- o_overrun  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- o_frame_err  out  1  one-cycle pulse: the stop bit was sampled low.

## Operation
- **Input synchronizer:** two flops on rx, both reset to 1. All logic below uses the second-stage output rx_s. A register rx_prev holds the previous rx_s value and resets to 0, so a line held low through reset never produces a start.
- **State machine:** IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_prev=1 and rx_s=0, load bit counter = clkdiv_rx/2 (integer division) and go to START.
  - START: when the counter expires, sample rx_s. If the sample is 1, this is a false start; go to IDLE. If it is 0, reload the counter to clkdiv_rx, clear the bit index, and go to DATA.
  - DATA: at each counter expiry, shift rx_s into the shift register LSB-first. After the 8th sample, go to STOP.
  - STOP: at counter expiry, sample rx_s.
    - If the sample is 1, push the byte and go to IDLE. The push is registered on that same edge, which leaves half a bit of margin for back-to-back frames.
    - If the sample is 0, pulse o_frame_err, discard the byte, and go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s=1, then go to IDLE. This covers break conditions.
- **Counter:** width is ceil(log2(clkdiv_rx+1)). It counts down and "expires" at the edge where it equals 1.
- **FIFO:**
  - Memory is 2^RX_SIZE × 8, first-word-fall-through.
  - Pointers are RX_SIZE bits and wrap naturally.
  - Occupancy count is RX_SIZE+1 bits.
  - Pop occurs on o_tvalid & o_tready.
  - A push is accepted if count < depth, or if a pop happens in the same cycle. The count is then unchanged and the write lands at the just-freed location.
  - Otherwise the byte is dropped and o_overrun pulses.
  - A simultaneous push and pop on an empty FIFO is impossible, because o_tvalid=0.

## Timing
- **Reset values:** o_tdata=0, o_tvalid=0, o_overrun=0, o_frame_err=0. Also: FIFO empty, pointers 0, state IDLE, sync flops 1, rx_prev 0.
- **Reset mid-frame:** the partial byte and all FIFO contents are discarded. Reception restarts only at a new 1→0 transition seen after release.
- **Sampling edges:** let E0 be the first clk edge at which the rx pin is sampled low.
  - The falling edge is detected in IDLE at E2.
  - The start bit is sampled at E(2+clkdiv_rx/2).
  - Data bit i (i=0..7) is sampled at E(2+clkdiv_rx/2+(i+1)·clkdiv_rx).
  - The stop bit is sampled at E(2+clkdiv_rx/2+9·clkdiv_rx). This is E477 at the default.
- **Output latency:** o_tvalid is high in the cycle after the stop-sample edge. o_tdata is valid in the same cycle.
- **Pulse timing:** o_frame_err and o_overrun are registered. Each is high for exactly the one cycle following the stop-sample edge.
- **Handshake:**
  - o_tdata and o_tvalid are stable while o_tvalid=1 and o_tready=0.
  - o_tvalid falls in the cycle after the last entry is popped, unless a push lands on that same edge.
- **Throughput:** the FIFO pop rate is one byte per cycle.

## Test plan
- **Single byte:** send 0xA5 with default parameters and o_tready=1. Required: o_tvalid high for exactly one cycle, first high after edge E477, with o_tdata=0xA5. No error pulses.
- **Burst and overrun:** with o_tready=0, send 17 back-to-back frames: 0x55,0x55,0x55,0x00,0xAA,0xFF,0x53,0xCA,0x5A,0xA5,0x55,0x55,0x00,0xAA,0xFF,0x53,0x18. Required: o_overrun pulses once, on the 17th frame. Then raise o_tready; exactly the first 16 bytes drain in order, one per cycle, and 0x18 is absent.
- **Glitch rejection:** hold rx low for 10 cycles, then high. Required: no o_tvalid and no error pulse, and the FSM is back in IDLE. A following frame with 0x3C is received correctly.
- **Frame error and break:** send 0x3C with the stop bit low, then hold rx low for 2000 cycles. Required: one o_frame_err pulse, no push, and no further frames or pulses until rx returns high. The next frame 0x81 is received.
- **Reset mid-frame:** assert rst during data bit 4 of a frame, with 3 bytes already queued. Required: all outputs 0 and the FIFO empty. After release, a frame carrying 0x18 yields o_tdata=0x18 only.
- **Full FIFO with simultaneous pop:** fill to 16 entries, then hold o_tready=1 so a pop coincides with the stop-sample push. Required: no o_overrun, the count stays 16, and the new byte appears last in drain order.
